icache: RTL and testbench
=========================

# icache

Direct-mapped, one-word-per-line instruction cache sitting between the fetch stage and the memory controller. Accepts one fetch request at a time from ifetch, answers hits in one cycle, and on a miss fetches the aligned word through the memory controller, fills the line and returns it. A redirect input from the ROB cancels delivery of an in-flight miss without corrupting the array.

## Interface
Parameters:
- INDEX_BITS, 6, line-index width; 2^INDEX_BITS lines of one 32-bit word each.

Ports:
- clk_in  in  1  clock; all state updates on the rising edge.
- rst_in  in  1  reset; synchronous, active-high.
- rdy_in  in  1  global ready; low freezes every register, outputs hold.
- to_icache  in  1  fetch strobe from ifetch; high for exactly one cycle per request.
- pc_to_icache  in  32  fetch address, valid with to_icache.
- have_result  out  1  one-cycle pulse: inst_from_icache valid.
- inst_from_icache  out  32  fetched instruction word.
- clear  in  1  ROB redirect; cancels any pending request.
- mem_req  out  1  word read request to memory controller, held until mem_ready.
- mem_addr  out  32  word-aligned read address (bits [1:0] = 0).
- mem_ready  in  1  one-cycle pulse: mem_data valid, request complete.
- mem_data  in  32  word returned by memory controller.

## Operation
- Address split: [1:0] ignored; index = [INDEX_BITS+1:2]; tag = [31:INDEX_BITS+2] (24 bits at default).
- Per line: valid bit, tag, 32-bit data. Reset clears all valid bits; data/tag arrays are not cleared.
- States: IDLE, MISS, DRAIN.
- IDLE, strobe sampled, clear low:
  - hit (valid and tag match): have_result<=1, inst_from_icache<=line data; stay IDLE.
  - miss: save index/tag, mem_req<=1, mem_addr<={pc[31:2],2'b00}; go MISS.
- MISS: hold mem_req/mem_addr. On mem_ready: write line (valid=1, tag, mem_data), have_result<=1, inst_from_icache<=mem_data, mem_req<=0; go IDLE.
- clear sampled in MISS (without mem_ready): go DRAIN; mem_req stays high (controller transaction is not abortable).
- DRAIN: on mem_ready: fill line as in MISS, have_result stays 0, mem_req<=0; go IDLE. Strobes in DRAIN are ignored.
- clear and mem_ready in the same MISS cycle: line filled, no have_result, go IDLE.
- clear with strobe in IDLE: request dropped, no lookup, no mem_req.
- Strobe while in MISS/DRAIN: ignored (ifetch never issues one).
- have_result is cleared on every ready cycle it is not being set.

## Timing
- Reset values: have_result 0, inst_from_icache 0, mem_req 0, mem_addr 0, state IDLE.
- Hit latency: strobe sampled at edge E; have_result high during cycle after E.
- Miss latency: mem_req high from edge E; have_result asserted on the edge that samples mem_ready; total = 1 + controller latency.
- Back-to-back hits: a strobe in the cycle have_result is high is accepted normally.
- rdy_in low: no state, array or output changes; mem_ready is not sampled (controller pauses on rdy_in too).
- rst_in mid-miss: state to IDLE, mem_req 0 next cycle, all lines invalid; the controller's in-flight reply is discarded.

## Structure
- const.v gains ICACHE_INDEX_BITS default and state encodings (IDLE=2'd0, MISS=2'd1, DRAIN=2'd2).
- Sub-module icache_array: valid/tag/data storage, combinational read by index, synchronous write port, synchronous valid clear on reset. icache holds FSM and memory handshake.

## Test plan
- Reset, strobe pc=0x0000_0000, mem_ready 3 cycles later with 0x0000_0013 -> mem_addr=0x0, have_result pulses once with 0x0000_0013; repeat strobe pc=0x0 -> hit, have_result one cycle after strobe, no mem_req.
- Fill pc=0x0000_0100, then strobe pc=0x0000_0200 (same index 0, different tag) -> miss, mem_addr=0x200, line replaced; strobe 0x100 again -> miss.
- Strobe pc=0x0000_0006 -> mem_addr=0x0000_0004; later strobe 0x4 hits.
- Miss on 0x40, clear two cycles later, mem_ready after 5 -> no have_result, mem_req held until mem_ready; strobe 0x40 afterwards hits with filled data.
- Strobe and clear same cycle -> no mem_req, no have_result; clear coincident with mem_ready -> fill, no have_result.
- rdy_in low for 4 cycles during miss and during a have_result pulse -> outputs held, single delivered result, no lost or duplicate pulse.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
// Imported by icache and icache_array.
package icache_pkg;

  localparam int unsigned ICACHE_INDEX_BITS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Line storage for the instruction cache: valid/tag/data per line.
// Combinational read by index, synchronous write, synchronous valid clear on reset.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [INDEX_BITS-1:0]   rd_index,
  output logic                    rd_valid,
  output logic [29-INDEX_BITS:0]  rd_tag,
  output logic [31:0]             rd_data,
  input  logic                    wr_en,
  input  logic [INDEX_BITS-1:0]   wr_index,
  input  logic [29-INDEX_BITS:0]  wr_tag,
  input  logic [31:0]             wr_data
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]          valid;
  logic [29-INDEX_BITS:0]    tag_mem  [LINES];
  logic [31:0]               data_mem [LINES];

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data are left uninitialised; valid alone qualifies them.
  always_ff @(posedge clk_in) begin
    if (!rst_in && wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between ifetch and the
// memory controller; FSM handles hits, misses and redirect-cancelled misses.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        to_icache,
  input  logic [31:0] pc_to_icache,
  output logic        have_result,
  output logic [31:0] inst_from_icache,
  input  logic        clear,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

  icache_state_t         state;
  logic [INDEX_BITS-1:0] rd_index;
  logic [TAG_BITS-1:0]   pc_tag;
  logic [INDEX_BITS-1:0] miss_index;
  logic [TAG_BITS-1:0]   miss_tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [31:0]           rd_data;
  logic                  hit;
  logic                  fill_en;
  logic                  unused_pc_bits;

  assign rd_index       = pc_to_icache[INDEX_BITS+1:2];
  assign pc_tag         = pc_to_icache[31:INDEX_BITS+2];
  assign unused_pc_bits = ^pc_to_icache[1:0];
  assign hit            = rd_valid && (rd_tag == pc_tag);

  // Fill happens in MISS and DRAIN alike; a redirect only suppresses delivery.
  assign fill_en = rdy_in && mem_ready && ((state == MISS) || (state == DRAIN));

  icache_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_index (rd_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_en),
    .wr_index (miss_index),
    .wr_tag   (miss_tag),
    .wr_data  (mem_data)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      have_result      <= 1'b0;
      inst_from_icache <= '0;
      mem_req          <= 1'b0;
      mem_addr         <= '0;
      miss_index       <= '0;
      miss_tag         <= '0;
    end else if (rdy_in) begin
      have_result <= 1'b0;
      case (state)
        IDLE: begin
          if (to_icache && !clear) begin
            if (hit) begin
              have_result      <= 1'b1;
              inst_from_icache <= rd_data;
            end else begin
              miss_index <= rd_index;
              miss_tag   <= pc_tag;
              mem_req    <= 1'b1;
              mem_addr   <= {pc_to_icache[31:2], 2'b00};
              state      <= MISS;
            end
          end
        end
        MISS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            if (!clear) begin
              have_result      <= 1'b1;
              inst_from_icache <= mem_data;
            end
          end else if (clear) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written corner
// sequences and randomized fetches against a line-level reference model.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        to_icache;
  logic [31:0] pc_to_icache;
  logic        have_result;
  logic [31:0] inst_from_icache;
  logic        clear;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: one entry per index, remembering the word address it holds.
  bit          mv [64];
  logic [29:0] ma [64];
  logic [31:0] md [64];

  always #5 clk_in = ~clk_in;

  icache #(
    .INDEX_BITS(6)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .to_icache        (to_icache),
    .pc_to_icache     (pc_to_icache),
    .have_result      (have_result),
    .inst_from_icache (inst_from_icache),
    .clear            (clear),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ready        (mem_ready),
    .mem_data         (mem_data)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] fill;
    int unsigned lat;
    bit          exp_hit;
    logic [31:0] exp_addr;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return 32'(pc[7:2]);
  endfunction

  task automatic model_fill(input logic [31:0] pc, input logic [31:0] d);
    mv[idx_of(pc)] = 1'b1;
    ma[idx_of(pc)] = pc[31:2];
    md[idx_of(pc)] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
  endtask

  task automatic fetch(input string nm, input logic [31:0] pc, input logic [31:0] fill,
                       input int unsigned lat, input bit exp_hit,
                       input logic [31:0] exp_addr, input logic [31:0] exp_inst);
    to_icache    = 1'b1;
    pc_to_icache = pc;
    step();
    to_icache    = 1'b0;
    pc_to_icache = $urandom;
    if (exp_hit) begin
      check({nm, "/hit_result"}, 32'(have_result), 32'd1);
      check({nm, "/hit_inst"}, inst_from_icache, exp_inst);
      check({nm, "/hit_no_req"}, 32'(mem_req), 32'd0);
    end else begin
      check({nm, "/miss_no_result"}, 32'(have_result), 32'd0);
      check({nm, "/miss_req"}, 32'(mem_req), 32'd1);
      check({nm, "/miss_addr"}, mem_addr, exp_addr);
      for (int unsigned c = 1; c < lat; c++) begin
        step();
        check({nm, "/req_held"}, 32'(mem_req), 32'd1);
        check({nm, "/early_result"}, 32'(have_result), 32'd0);
      end
      mem_ready = 1'b1;
      mem_data  = fill;
      step();
      mem_ready = 1'b0;
      mem_data  = $urandom;
      check({nm, "/fill_result"}, 32'(have_result), 32'd1);
      check({nm, "/fill_inst"}, inst_from_icache, exp_inst);
      check({nm, "/fill_req_drop"}, 32'(mem_req), 32'd0);
      model_fill(pc, fill);
    end
    step();
    check({nm, "/pulse_end"}, 32'(have_result), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0000_0013, 3, 1'b0, 32'h0000_0000, 32'h0000_0013};
    vecs[1] = '{32'h0000_0000, 32'h0,         1, 1'b1, 32'h0,         32'h0000_0013};
    vecs[2] = '{32'h0000_0100, 32'hA1A1_0100, 2, 1'b0, 32'h0000_0100, 32'hA1A1_0100};
    vecs[3] = '{32'h0000_0200, 32'hB2B2_0200, 1, 1'b0, 32'h0000_0200, 32'hB2B2_0200};
    vecs[4] = '{32'h0000_0100, 32'hC3C3_0100, 4, 1'b0, 32'h0000_0100, 32'hC3C3_0100};
    vecs[5] = '{32'h0000_0006, 32'h0000_0055, 2, 1'b0, 32'h0000_0004, 32'h0000_0055};
    vecs[6] = '{32'h0000_0004, 32'h0,         1, 1'b1, 32'h0,         32'h0000_0055};
    vecs[7] = '{32'h0000_0200, 32'hD4D4_0200, 1, 1'b0, 32'h0000_0200, 32'hD4D4_0200};

    rst_in       = 1'b1;
    rdy_in       = 1'b1;
    to_icache    = 1'b0;
    pc_to_icache = '0;
    clear        = 1'b0;
    mem_ready    = 1'b0;
    mem_data     = '0;
    model_reset();
    repeat (3) step();
    rst_in = 1'b0;
    check("rst/have_result", 32'(have_result), 32'd0);
    check("rst/inst", inst_from_icache, 32'd0);
    check("rst/mem_req", 32'(mem_req), 32'd0);
    check("rst/mem_addr", mem_addr, 32'd0);

    for (int i = 0; i < 8; i++)
      fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].fill, vecs[i].lat,
            vecs[i].exp_hit, vecs[i].exp_addr, vecs[i].exp_inst);

    // Back-to-back hits: new strobe while have_result is high.
    to_icache    = 1'b1;
    pc_to_icache = 32'h0000_0004;
    step();
    check("b2b/first", 32'(have_result), 32'd1);
    step();
    to_icache = 1'b0;
    check("b2b/second", 32'(have_result), 32'd1);
    check("b2b/inst", inst_from_icache, 32'h0000_0055);
    step();
    check("b2b/end", 32'(have_result), 32'd0);

    // Redirect two cycles into a miss; memory reply five cycles later.
    to_icache    = 1'b1;
    pc_to_icache = 32'h0000_0040;
    step();
    to_icache = 1'b0;
    check("drain/req", 32'(mem_req), 32'd1);
    check("drain/addr", mem_addr, 32'h0000_0040);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (3) begin
      step();
      check("drain/req_held", 32'(mem_req), 32'd1);
      check("drain/no_result", 32'(have_result), 32'd0);
    end
    mem_ready = 1'b1;
    mem_data  = 32'hDEAD_0040;
    step();
    mem_ready = 1'b0;
    check("drain/done_no_result", 32'(have_result), 32'd0);
    check("drain/req_drop", 32'(mem_req), 32'd0);
    model_fill(32'h0000_0040, 32'hDEAD_0040);
    step();
    check("drain/still_no_result", 32'(have_result), 32'd0);
    fetch("drain_refetch", 32'h0000_0040, 32'h0, 1, 1'b1, 32'h0, 32'hDEAD_0040);

    // Strobe and clear together: miss address and hit address both dropped.
    to_icache    = 1'b1;
    clear        = 1'b1;
    pc_to_icache = 32'h0000_0300;
    step();
    check("strclr_miss/req", 32'(mem_req), 32'd0);
    check("strclr_miss/result", 32'(have_result), 32'd0);
    pc_to_icache = 32'h0000_0040;
    step();
    to_icache = 1'b0;
    clear     = 1'b0;
    check("strclr_hit/result", 32'(have_result), 32'd0);
    check("strclr_hit/req", 32'(mem_req), 32'd0);

    // Clear coincident with mem_ready.
    to_icache    = 1'b1;
    pc_to_icache = 32'h0000_0500;
    step();
    to_icache = 1'b0;
    check("coinc/req", 32'(mem_req), 32'd1);
    step();
    mem_ready = 1'b1;
    clear     = 1'b1;
    mem_data  = 32'hC0FF_EE00;
    step();
    mem_ready = 1'b0;
    clear     = 1'b0;
    check("coinc/no_result", 32'(have_result), 32'd0);
    check("coinc/req_drop", 32'(mem_req), 32'd0);
    model_fill(32'h0000_0500, 32'hC0FF_EE00);
    step();
    fetch("coinc_refetch", 32'h0000_0500, 32'h0, 1, 1'b1, 32'h0, 32'hC0FF_EE00);

    // rdy_in low during a miss (mem_ready must not be sampled) and during the pulse.
    to_icache    = 1'b1;
    pc_to_icache = 32'h0000_0600;
    step();
    to_icache = 1'b0;
    check("stall/req", 32'(mem_req), 32'd1);
    rdy_in    = 1'b0;
    mem_ready = 1'b1;
    mem_data  = 32'h0000_0BAD;
    repeat (4) begin
      step();
      check("stall_miss/req_held", 32'(mem_req), 32'd1);
      check("stall_miss/no_result", 32'(have_result), 32'd0);
    end
    rdy_in   = 1'b1;
    mem_data = 32'h0600_0600;
    step();
    mem_ready = 1'b0;
    check("stall/result", 32'(have_result), 32'd1);
    check("stall/inst", inst_from_icache, 32'h0600_0600);
    model_fill(32'h0000_0600, 32'h0600_0600);
    rdy_in = 1'b0;
    repeat (4) begin
      step();
      check("stall_pulse/held", 32'(have_result), 32'd1);
      check("stall_pulse/inst", inst_from_icache, 32'h0600_0600);
    end
    rdy_in = 1'b1;
    step();
    check("stall_pulse/end", 32'(have_result), 32'd0);
    check("stall_pulse/no_req", 32'(mem_req), 32'd0);

    // Randomized fetches over a small address pool to mix hits, misses and evictions.
    for (int k = 0; k < 60; k++) begin
      logic [31:0] pc;
      logic [31:0] fill;
      bit          exp_hit;
      pc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 2)
           | 32'($urandom_range(0, 3));
      fill    = $urandom;
      exp_hit = mv[idx_of(pc)] && (ma[idx_of(pc)] == pc[31:2]);
      fetch("rand", pc, fill, $urandom_range(1, 4), exp_hit, {pc[31:2], 2'b00},
            exp_hit ? md[idx_of(pc)] : fill);
    end

    // Reset in the middle of a miss invalidates every line.
    to_icache    = 1'b1;
    pc_to_icache = 32'h0000_0700;
    step();
    to_icache = 1'b0;
    check("rstmiss/req", 32'(mem_req), 32'd1);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    model_reset();
    check("rstmiss/req_drop", 32'(mem_req), 32'd0);
    check("rstmiss/result", 32'(have_result), 32'd0);
    check("rstmiss/addr", mem_addr, 32'd0);
    step();
    check("rstmiss/idle_no_req", 32'(mem_req), 32'd0);
    fetch("post_rst_0", 32'h0000_0000, 32'h7777_0000, 2, 1'b0, 32'h0, 32'h7777_0000);
    fetch("post_rst_40", 32'h0000_0040, 32'h7777_0040, 1, 1'b0, 32'h40, 32'h7777_0040);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
